// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results into an in-order FIFO that
// retires one register-file write per cycle, with pending scoreboard and forwarding.
module wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 2,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  input  logic [REG_AW-1:0]       alu_dest,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    alu_ready,
  input  logic                    ld_valid,
  input  logic [REG_AW-1:0]       ld_dest,
  input  logic [DATA_W-1:0]       ld_data,
  output logic                    ld_ready,
  output logic                    rf_write_enable,
  output logic [REG_AW-1:0]       rf_reg_dest,
  output logic [DATA_W-1:0]       rf_write_data,
  output logic [(1<<REG_AW)-1:0]  pending,
  input  logic [REG_AW-1:0]       fwd_addr,
  output logic                    fwd_hit,
  output logic [DATA_W-1:0]       fwd_data,
  output logic                    busy
);
  localparam int NREG = 1 << REG_AW;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);

  // Handshake: a source transfers on the rising edge where valid & ready are
  // both high; ready depends only on registered count, never on valid.

  logic [REG_AW-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, ld_slot, fwd_idx;
  logic [CW-1:0]     count, free;
  logic [CW-1:0]     sb_cnt [NREG];
  logic              alu_acc, ld_acc, pop;

  assign free      = CW'(DEPTH) - count;
  assign alu_ready = (free >= CW'(1));
  assign ld_ready  = (free >= CW'(2));
  assign alu_acc   = alu_valid & alu_ready;
  assign ld_acc    = ld_valid & ld_ready;
  assign pop       = (count != '0);
  // The load entry lands behind the ALU entry when both are accepted together.
  assign ld_slot   = wr_ptr + PW'(alu_acc);

  assign rf_write_enable = pop;
  assign rf_reg_dest     = dest_q[rd_ptr];
  assign rf_write_data   = data_q[rd_ptr];
  assign busy            = pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (alu_acc) begin
        dest_q[wr_ptr] <= alu_dest;
        data_q[wr_ptr] <= alu_data;
      end
      if (ld_acc) begin
        dest_q[ld_slot] <= ld_dest;
        data_q[ld_slot] <= ld_data;
      end
      wr_ptr <= wr_ptr + PW'(alu_acc) + PW'(ld_acc);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(alu_acc) + CW'(ld_acc) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) sb_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        sb_cnt[r] <= sb_cnt[r]
                   + CW'(alu_acc && (alu_dest == REG_AW'(r)))
                   + CW'(ld_acc && (ld_dest == REG_AW'(r)))
                   - CW'(pop && (dest_q[rd_ptr] == REG_AW'(r)));
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < NREG; r++) pending[r] = (sb_cnt[r] != '0);
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (dest_q[fwd_idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end
endmodule
